// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit holding HI/LO; shift-add multiply, restoring divide, STEP bits per cycle.
// Optional MULDIV_SIGNED_EN enables MULT/DIV (two's-complement); otherwise ops 001/011 are invalid.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] arg1,
  input  logic [WIDTH-1:0] arg2,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             err,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned ITER = WIDTH / STEP;
  localparam int unsigned CW   = $clog2(ITER + 1);

  if (!((STEP == 1) || (STEP == 2) || (STEP == 4)) || ((WIDTH % STEP) != 0)) begin : g_param_check
    $error("muldiv_unit: STEP must be 1, 2 or 4 and divide WIDTH evenly");
  end

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               mt_done_q, mt_done_d;
  logic               dz_q, dz_d;
  logic               err_q, err_d;

  logic               op_mul, op_div, op_mthi, op_mtlo, accept;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] fix_res, mul_step, div_step;

  assign op_mthi = (op == 3'b100);
  assign op_mtlo = (op == 3'b101);
  assign accept  = (state_q == S_IDLE) && start && !flush && (op_mul || op_div);

`ifdef MULDIV_SIGNED_EN
  logic a_neg, b_neg, op_signed;
  logic div_q, neg_lo_q, neg_hi_q;

  assign op_mul    = (op[2:1] == 2'b00);
  assign op_div    = (op[2:1] == 2'b01);
  assign op_signed = op[0] & ~op[2];
  assign a_neg     = op_signed & arg1[WIDTH-1];
  assign b_neg     = op_signed & arg2[WIDTH-1];
  assign a_mag     = a_neg ? -arg1 : arg1;
  assign b_mag     = b_neg ? -arg2 : arg2;

  // Iterations run on magnitudes; the signs needed by FIX are captured at accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q    <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
    end else if (accept) begin
      div_q    <= op_div;
      neg_lo_q <= a_neg ^ b_neg;
      neg_hi_q <= a_neg & op_div;
    end
  end

  always_comb begin
    fix_res = acc_q;
    if (div_q) begin
      fix_res[WIDTH-1:0]       = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      fix_res[2*WIDTH-1:WIDTH] = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end else if (neg_lo_q) begin
      fix_res = -acc_q;
    end
  end
`else
  assign op_mul  = (op == 3'b000);
  assign op_div  = (op == 3'b010);
  assign a_mag   = arg1;
  assign b_mag   = arg2;
  assign fix_res = acc_q;
`endif

  // Multiply: acc = {partial, multiplier}; add multiplicand on LSB, shift right.
  always_comb begin
    logic [WIDTH:0] sum;
    mul_step = acc_q;
    sum      = '0;
    for (int unsigned i = 0; i < STEP; i++) begin
      sum      = {1'b0, mul_step[2*WIDTH-1:WIDTH]} + (mul_step[0] ? {1'b0, opnd_q} : '0);
      mul_step = {sum, mul_step[WIDTH-1:1]};
    end
  end

  // Divide: acc = {remainder, dividend/quotient}; shift left, subtract if it fits.
  always_comb begin
    logic [WIDTH:0]   rs;
    logic [WIDTH-1:0] r, q;
    r  = acc_q[2*WIDTH-1:WIDTH];
    q  = acc_q[WIDTH-1:0];
    rs = '0;
    for (int unsigned i = 0; i < STEP; i++) begin
      rs = {r, q[WIDTH-1]};
      q  = {q[WIDTH-2:0], 1'b0};
      if (rs >= {1'b0, opnd_q}) begin
        rs   = rs - {1'b0, opnd_q};
        q[0] = 1'b1;
      end
      r = rs[WIDTH-1:0];
    end
    div_step = {r, q};
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    mt_done_d = 1'b0;
    dz_d      = 1'b0;
    err_d     = 1'b0;
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (op_mul) begin
              state_d = S_MUL;
              cnt_d   = '0;
              acc_d   = {{WIDTH{1'b0}}, b_mag};
              opnd_d  = a_mag;
            end else if (op_div) begin
              if (arg2 == '0) begin
                state_d = S_DONE;
                dz_d    = 1'b1;
              end else begin
                state_d = S_DIV;
                cnt_d   = '0;
                acc_d   = {{WIDTH{1'b0}}, a_mag};
                opnd_d  = b_mag;
              end
            end else if (op_mthi) begin
              hi_d      = arg1;
              mt_done_d = 1'b1;
            end else if (op_mtlo) begin
              lo_d      = arg1;
              mt_done_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        S_MUL, S_DIV: begin
          acc_d = (state_q == S_MUL) ? mul_step : div_step;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(ITER - 1)) begin
            state_d = S_FIX;
            cnt_d   = '0;
          end
        end
        S_FIX: begin
          state_d      = S_DONE;
          {hi_d, lo_d} = fix_res;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
      if (start && (state_q != S_IDLE)) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      mt_done_q <= 1'b0;
      dz_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      mt_done_q <= mt_done_d;
      dz_q      <= dz_d;
      err_q     <= err_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE) || mt_done_q;
  assign div_zero = dz_q;
  assign err      = err_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table for single operations plus hand sequences for
// busy/err, flush, async reset and a STEP=4 instance.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, flush;
  logic [2:0]  op;
  logic [31:0] arg1, arg2;
  logic        busy, done, div_zero, err;
  logic [31:0] hi, lo;

  logic        s4_start, s4_flush;
  logic [2:0]  s4_op;
  logic [31:0] s4_arg1, s4_arg2;
  logic        s4_busy, s4_done, s4_dz, s4_err;
  logic [31:0] s4_hi, s4_lo;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32), .STEP(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .arg1(arg1), .arg2(arg2),
    .flush(flush), .busy(busy), .done(done), .div_zero(div_zero), .err(err),
    .hi(hi), .lo(lo)
  );

  muldiv_unit #(.WIDTH(32), .STEP(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(s4_start), .op(s4_op), .arg1(s4_arg1), .arg2(s4_arg2),
    .flush(s4_flush), .busy(s4_busy), .done(s4_done), .div_zero(s4_dz), .err(s4_err),
    .hi(s4_hi), .lo(s4_lo)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int unsigned lat;
    logic        busy;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input logic edz,
                        input int unsigned elat, input logic ebusy, input string nm);
    int unsigned cyc;
    bit          seen;
    @(negedge clk);
    start = 1'b1; op = o; arg1 = a; arg2 = b;
    @(posedge clk);
    #1;
    start = 1'b0; op = 3'b111; arg1 = 32'hDEAD_BEEF; arg2 = 32'h0BAD_F00D;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) seen = 1'b1;
    end
    chk({nm, " latency"}, 64'(cyc), 64'(elat));
    chk({nm, " busy"}, 64'(busy), 64'(ebusy));
    chk({nm, " hi"}, 64'(hi), 64'(eh));
    chk({nm, " lo"}, 64'(lo), 64'(el));
    chk({nm, " div_zero"}, 64'(div_zero), 64'(edz));
    @(negedge clk);
    chk({nm, " done pulse ends"}, 64'(done), 64'd0);
  endtask

  task automatic run4(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] eh, input logic [31:0] el, input string nm);
    int unsigned cyc;
    bit          seen;
    @(negedge clk);
    s4_start = 1'b1; s4_op = o; s4_arg1 = a; s4_arg2 = b;
    @(posedge clk);
    #1;
    s4_start = 1'b0; s4_arg1 = '0; s4_arg2 = '0;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (s4_done === 1'b1) seen = 1'b1;
    end
    chk({nm, " latency"}, 64'(cyc), 64'd10);
    chk({nm, " hi"}, 64'(s4_hi), 64'(eh));
    chk({nm, " lo"}, 64'(s4_lo), 64'(el));
  endtask

  task automatic expect_reject(input logic [2:0] o, input string nm);
    bit saw_done;
    @(negedge clk);
    start = 1'b1; op = o; arg1 = 32'h1111_2222; arg2 = 32'h3;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk({nm, " err"}, 64'(err), 64'd1);
    chk({nm, " busy"}, 64'(busy), 64'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) saw_done = 1'b1;
      @(negedge clk);
    end
    chk({nm, " no done"}, 64'(saw_done), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned cyc;
    bit          seen;
    logic [31:0] keep_lo;

    vecs[0]  = '{3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 34, 1'b1};
    vecs[1]  = '{3'b010, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0, 34, 1'b1};
    vecs[2]  = '{3'b101, 32'h0000_0055, 32'h0,         32'd2,         32'h0000_0055, 1'b0, 1,  1'b0};
    vecs[3]  = '{3'b100, 32'hA5A5_A5A5, 32'h0,         32'hA5A5_A5A5, 32'h0000_0055, 1'b0, 1,  1'b0};
    vecs[4]  = '{3'b010, 32'h0000_1234, 32'h0,         32'hA5A5_A5A5, 32'h0000_0055, 1'b1, 1,  1'b1};
    vecs[5]  = '{3'b000, 32'h1234_5678, 32'h10,        32'h0000_0001, 32'h2345_6780, 1'b0, 34, 1'b1};
    vecs[6]  = '{3'b010, 32'd5,         32'd9,         32'd5,         32'd0,         1'b0, 34, 1'b1};
    vecs[7]  = '{3'b010, 32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF, 1'b0, 34, 1'b1};
    vecs[8]  = '{3'b000, 32'h0,         32'hDEAD_BEEF, 32'h0,         32'h0,         1'b0, 34, 1'b1};
    vecs[9]  = '{3'b010, 32'h8000_0000, 32'h10,        32'h0,         32'h0800_0000, 1'b0, 34, 1'b1};
    vecs[10] = '{3'b000, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0,         1'b0, 34, 1'b1};
    vecs[11] = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         32'd1,         1'b0, 34, 1'b1};
    vecs[12] = '{3'b000, 32'h0000_FFFF, 32'h0001_0001, 32'h0,         32'hFFFF_FFFF, 1'b0, 34, 1'b1};

    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = '0; arg1 = '0; arg2 = '0;
    s4_start = 1'b0; s4_flush = 1'b0; s4_op = '0; s4_arg1 = '0; s4_arg2 = '0;
    repeat (3) @(negedge clk);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset err", 64'(err), 64'd0);
    chk("reset div_zero", 64'(div_zero), 64'd0);
    chk("reset hi", 64'(hi), 64'd0);
    chk("reset lo", 64'(lo), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dz,
             vecs[i].lat, vecs[i].busy, $sformatf("vec%0d", i));

`ifdef MULDIV_SIGNED_EN
    run_op(3'b011, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34, 1'b1, "DIV -7/2");
    run_op(3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 1'b0, 34, 1'b1, "DIV MOST_NEG/-1");
    run_op(3'b001, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 34, 1'b1, "MULT -3*5");
    run_op(3'b011, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0, 34, 1'b1, "DIV 7/-2");
`else
    expect_reject(3'b001, "unsigned-build MULT");
    expect_reject(3'b011, "unsigned-build DIV");
`endif
    expect_reject(3'b110, "invalid op 110");

    // start while busy, then start during the done cycle
    @(negedge clk);
    start = 1'b1; op = 3'b000; arg1 = 32'd6; arg2 = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; op = 3'b010; arg1 = 32'd9; arg2 = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("busy start err", 64'(err), 64'd1);
    chk("busy start still busy", 64'(busy), 64'd1);
    @(negedge clk);
    chk("busy start err pulse ends", 64'(err), 64'd0);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 100) begin
      if (done === 1'b1) seen = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("busy start seen done", 64'(seen), 64'd1);
    chk("busy start hi", 64'(hi), 64'd0);
    chk("busy start lo", 64'(lo), 64'd42);
    start = 1'b1; op = 3'b101; arg1 = 32'h77;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("start at done err", 64'(err), 64'd1);
    chk("start at done lo", 64'(lo), 64'd42);
    chk("start at done no done", 64'(done), 64'd0);
    run_op(3'b101, 32'h77, 32'h0, 32'h0, 32'h77, 1'b0, 1, 1'b0, "MTLO after refuse");

    // flush mid-operation
    @(negedge clk);
    start = 1'b1; op = 3'b000; arg1 = 32'hFFFF_FFFF; arg2 = 32'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush busy", 64'(busy), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) seen = 1'b1;
      @(negedge clk);
    end
    chk("flush no done", 64'(seen), 64'd0);
    chk("flush hi", 64'(hi), 64'd0);
    chk("flush lo", 64'(lo), 64'h77);

    // flush and start together in IDLE
    start = 1'b1; flush = 1'b1; op = 3'b000; arg1 = 32'd3; arg2 = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush+start busy", 64'(busy), 64'd0);
    chk("flush+start err", 64'(err), 64'd0);

    // async reset mid-operation
    start = 1'b1; op = 3'b000; arg1 = 32'd3; arg2 = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(negedge clk);
    keep_lo = lo;
    chk("pre-reset busy", 64'(busy), 64'd1);
    chk("pre-reset lo", 64'(keep_lo), 64'h77);
    #1 rst_n = 1'b0;
    #1;
    chk("async reset busy", 64'(busy), 64'd0);
    chk("async reset hi", 64'(hi), 64'd0);
    chk("async reset lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run4(3'b000, 32'h0001_0000, 32'h0001_0000, 32'h1, 32'h0, "STEP4 MULTU");
    run4(3'b010, 32'd100, 32'd7, 32'd2, 32'd14, "STEP4 DIVU");
    run4(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, "STEP4 MULTU max");

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
